ifu_fetch: RTL and testbench

- Instruction fetch unit: holds the architectural PC and fetches the instruction word at PC from instruction memory using a req/ack handshake.
- Presents the word and its address to decode and to the next-PC logic.
- Loads the next-PC result when the core retires the current instruction.
- Sits directly upstream of next-PC computation and consumes its output.

---
 rtl/ifu_fetch_pkg.sv | 18 +
 rtl/ifu_fetch_if.sv | 25 ++
 rtl/ifu_fetch.sv | 102 ++++++++++
 tb/tb_ifu_fetch.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ifu_fetch_pkg.sv
// rtl/ifu_fetch_pkg.sv - shared types and constants for the instruction fetch unit
package ifu_fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    function automatic logic misaligned(input logic [XLEN-1:0] addr);
        return |addr[1:0];
    endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// rtl/ifu_fetch_if.sv - instruction memory and decode-side signals of the fetch unit
interface ifu_fetch_if;
    import ifu_fetch_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            imem_ack;
    logic [XLEN-1:0] ins;
    logic [XLEN-1:0] ins_addr;
    logic            ins_valid;
    logic [XLEN-1:0] next_ins_addr;
    logic            pc_update;

    modport master (
        output imem_req, imem_addr, ins, ins_addr, ins_valid,
        input  imem_rdata, imem_ack, next_ins_addr, pc_update
    );

    modport slave (
        input  imem_req, imem_addr, ins, ins_addr, ins_valid,
        output imem_rdata, imem_ack, next_ins_addr, pc_update
    );

endinterface

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - PC register and req/ack fetch FSM feeding decode and next-PC logic
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          TIMEOUT  = 16,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    ifu_fetch_if.master      bus,
    output logic             fault,
    output logic [CNT_W-1:0] fetch_count
);

    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t          state, state_next;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ins;
    logic            imem_req;
    logic            ins_valid;
    logic [TMO_W-1:0] tmo_cnt;

    logic load_ins, load_pc, tmo_clr, tmo_inc;

    always_comb begin
        state_next = state;
        load_ins   = 1'b0;
        load_pc    = 1'b0;
        tmo_clr    = 1'b0;
        tmo_inc    = 1'b0;
        case (state)
            ST_IDLE: begin
                state_next = ST_FETCH;
                tmo_clr    = 1'b1;
            end
            ST_FETCH: begin
                // ack has priority over a timeout landing on the same edge
                if (bus.imem_ack) begin
                    state_next = ST_VALID;
                    load_ins   = 1'b1;
                end else if (TIMEOUT != 0 && tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                    state_next = ST_FAULT;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            ST_VALID: begin
                if (bus.pc_update) begin
                    load_pc = 1'b1;
                    if (misaligned(bus.next_ins_addr)) begin
                        state_next = ST_FAULT;
                    end else begin
                        state_next = ST_FETCH;
                        tmo_clr    = 1'b1;
                    end
                end
            end
            ST_FAULT: state_next = ST_FAULT;
            default:  state_next = ST_FAULT;
        endcase
    end

    // Status outputs are registered from the next state so they track state exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            ins         <= '0;
            imem_req    <= 1'b0;
            ins_valid   <= 1'b0;
            fault       <= 1'b0;
            fetch_count <= '0;
            tmo_cnt     <= '0;
        end else begin
            state     <= state_next;
            imem_req  <= (state_next == ST_FETCH);
            ins_valid <= (state_next == ST_VALID);
            fault     <= (state_next == ST_FAULT);
            if (load_ins) begin
                ins         <= bus.imem_rdata;
                fetch_count <= fetch_count + CNT_W'(1);
            end
            if (load_pc) begin
                pc <= bus.next_ins_addr;
            end
            if (tmo_clr) begin
                tmo_cnt <= '0;
            end else if (tmo_inc) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
        end
    end

    assign bus.imem_req  = imem_req;
    assign bus.imem_addr = pc;
    assign bus.ins       = ins;
    assign bus.ins_addr  = pc;
    assign bus.ins_valid = ins_valid;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - directed self-checking bench for ifu_fetch
module tb_ifu_fetch;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       fault;
    logic [2:0] fetch_count;

    int errors = 0;
    int checks = 0;

    ifu_fetch_if bus ();

    ifu_fetch #(
        .RESET_PC(32'h0000_3000),
        .TIMEOUT (16),
        .CNT_W   (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .fault      (fault),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic fetch_ack(input logic [31:0] data);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = data;
        step();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
    endtask

    task automatic do_update(input logic [31:0] addr);
        bus.pc_update     = 1'b1;
        bus.next_ins_addr = addr;
        step();
        bus.pc_update     = 1'b0;
        bus.next_ins_addr = 32'h0;
    endtask

    task automatic release_reset();
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        int n;
        logic req_seen;

        bus.imem_ack      = 1'b0;
        bus.imem_rdata    = 32'h0;
        bus.pc_update     = 1'b0;
        bus.next_ins_addr = 32'h0;

        step();
        chk("rst_req",   {31'b0, bus.imem_req},  32'h0);
        chk("rst_valid", {31'b0, bus.ins_valid}, 32'h0);
        chk("rst_fault", {31'b0, fault},         32'h0);
        chk("rst_cnt",   {29'b0, fetch_count},   32'h0);
        chk("rst_ins",   bus.ins,                32'h0);
        chk("rst_addr",  bus.imem_addr,          32'h0000_3000);

        // first fetch, ack on first req cycle
        release_reset();
        chk("f1_req",  {31'b0, bus.imem_req}, 32'h1);
        chk("f1_addr", bus.imem_addr,         32'h0000_3000);
        fetch_ack(32'h2408_0005);
        chk("f1_ins",   bus.ins,                32'h2408_0005);
        chk("f1_valid", {31'b0, bus.ins_valid}, 32'h1);
        chk("f1_cnt",   {29'b0, fetch_count},   32'h1);
        chk("f1_reqlo", {31'b0, bus.imem_req},  32'h0);

        // sequential fetch with three wait cycles
        do_update(32'h0000_3004);
        chk("f2_valid", {31'b0, bus.ins_valid}, 32'h0);
        chk("f2_req",   {31'b0, bus.imem_req},  32'h1);
        chk("f2_addr",  bus.imem_addr,          32'h0000_3004);
        step(); step(); step();
        chk("f2_wait_req", {31'b0, bus.imem_req},  32'h1);
        chk("f2_wait_val", {31'b0, bus.ins_valid}, 32'h0);
        fetch_ack(32'h8C09_0010);
        chk("f2_ins",   bus.ins,                32'h8C09_0010);
        chk("f2_valid1", {31'b0, bus.ins_valid}, 32'h1);
        chk("f2_cnt",   {29'b0, fetch_count},   32'h2);

        // spurious ack in VALID
        fetch_ack(32'hDEAD_BEEF);
        chk("sp_ack_ins", bus.ins,              32'h8C09_0010);
        chk("sp_ack_cnt", {29'b0, fetch_count}, 32'h2);
        chk("sp_ack_val", {31'b0, bus.ins_valid}, 32'h1);

        // spurious pc_update in FETCH
        do_update(32'h0000_3008);
        do_update(32'h0000_4000);
        chk("sp_upd_addr", bus.imem_addr,         32'h0000_3008);
        chk("sp_upd_req",  {31'b0, bus.imem_req}, 32'h1);
        fetch_ack(32'h0000_0013);
        chk("f3_ins",  bus.ins,              32'h0000_0013);
        chk("f3_addr", bus.ins_addr,         32'h0000_3008);
        chk("f3_cnt",  {29'b0, fetch_count}, 32'h3);
        step();
        chk("f3_once_addr", bus.ins_addr, 32'h0000_3008);

        // self-loop refetch
        do_update(32'h0000_3008);
        chk("loop_req",  {31'b0, bus.imem_req}, 32'h1);
        chk("loop_addr", bus.imem_addr,         32'h0000_3008);
        fetch_ack(32'h1111_2222);
        chk("loop_ins", bus.ins,              32'h1111_2222);
        chk("loop_cnt", {29'b0, fetch_count}, 32'h4);

        // four more fetches wrap the 3-bit counter to 0
        for (int i = 0; i < 4; i++) begin
            do_update(32'h0000_3100 + 32'(4 * i));
            fetch_ack(32'h0100_0000 + 32'(i));
            chk("wrap_cnt", {29'b0, fetch_count}, 32'((5 + i) % 8));
        end
        chk("wrap_ins", bus.ins, 32'h0100_0003);

        // timeout: req high exactly 16 cycles
        do_update(32'h0000_3200);
        n = 0;
        while (bus.imem_req && n < 40) begin
            n++;
            step();
        end
        chk("tmo_cycles", 32'(n),                 32'd16);
        chk("tmo_fault",  {31'b0, fault},         32'h1);
        chk("tmo_req",    {31'b0, bus.imem_req},  32'h0);
        fetch_ack(32'hABCD_0000);
        step();
        chk("late_ins",   bus.ins,                32'h0100_0003);
        chk("late_cnt",   {29'b0, fetch_count},   32'h0);
        chk("late_fault", {31'b0, fault},         32'h1);
        chk("late_valid", {31'b0, bus.ins_valid}, 32'h0);

        // misaligned next PC
        reset = 1'b1;
        release_reset();
        fetch_ack(32'h2408_0005);
        do_update(32'h0000_3006);
        chk("mis_fault", {31'b0, fault}, 32'h1);
        req_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            req_seen |= bus.imem_req;
            step();
        end
        chk("mis_req",   {31'b0, req_seen},      32'h0);
        chk("mis_pc",    bus.ins_addr,           32'h0000_3006);
        chk("mis_valid", {31'b0, bus.ins_valid}, 32'h0);
        chk("mis_fault2", {31'b0, fault},        32'h1);

        // reset mid-FETCH
        reset = 1'b1;
        release_reset();
        fetch_ack(32'h2408_0005);
        do_update(32'h0000_3010);
        chk("mid_req_pre", {31'b0, bus.imem_req}, 32'h1);
        #1 reset = 1'b1;
        #1;
        chk("mid_req",   {31'b0, bus.imem_req},  32'h0);
        chk("mid_addr",  bus.imem_addr,          32'h0000_3000);
        chk("mid_cnt",   {29'b0, fetch_count},   32'h0);
        chk("mid_ins",   bus.ins,                32'h0);
        chk("mid_valid", {31'b0, bus.ins_valid}, 32'h0);
        release_reset();
        chk("res_req",  {31'b0, bus.imem_req}, 32'h1);
        chk("res_addr", bus.imem_addr,         32'h0000_3000);
        fetch_ack(32'h2408_0005);
        chk("res_ins", bus.ins,              32'h2408_0005);
        chk("res_cnt", {29'b0, fetch_count}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
